// File: rtl/aemb_wb_ram.sv
// aemb_wb_ram: true dual-port word RAM with independent wait-state Wishbone responders
//   sys_clk_i/sys_rst_i : clock, synchronous active-high reset
//   iwb_*               : read-only instruction port (IWS wait states)
//   dwb_*               : read/write data port (DWS wait states), big-endian byte lanes
module aemb_wb_ram #(
  parameter int AW  = 16,
  parameter int IWS = 0,
  parameter int DWS = 0
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [AW-1:2] iwb_adr_i,
  input  logic          iwb_stb_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic [AW-1:2] dwb_adr_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [2:0] IWS3 = 3'(IWS);
  localparam logic [2:0] DWS3 = 3'(DWS);
  logic [31:0] mem [0:(1<<(AW-2))-1];
  state_t        i_state_q, i_state_d, d_state_q, d_state_d;
  logic [2:0]    i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [AW-1:2] i_adr_q, i_adr_d, d_adr_q, d_adr_d;
  logic          d_wre_q, d_wre_d;
  logic [3:0]    d_sel_q, d_sel_d;
  logic [31:0]   d_dat_q, d_dat_d;
  logic          i_hit, d_hit;
  // The _d request fields are the live inputs in IDLE and the latched copy
  // otherwise, so the ACK-entry access always uses the accepted request.
  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_adr_d   = i_adr_q;
    i_hit     = 1'b0;
    case (i_state_q)
      IDLE: if (iwb_stb_i) begin
        i_adr_d   = iwb_adr_i;
        i_state_d = IWS3 == 3'd0 ? ACK : WAIT;
        i_cnt_d   = IWS3;
        i_hit     = IWS3 == 3'd0;
      end
      WAIT: begin
        i_state_d = !iwb_stb_i ? IDLE : i_cnt_q == 3'd1 ? ACK : WAIT;
        i_cnt_d   = !iwb_stb_i ? 3'd0 : i_cnt_q - 3'd1;
        i_hit     = iwb_stb_i && i_cnt_q == 3'd1;
      end
      default: i_state_d = IDLE;
    endcase
  end
  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_adr_d   = d_adr_q;
    d_wre_d   = d_wre_q;
    d_sel_d   = d_sel_q;
    d_dat_d   = d_dat_q;
    d_hit     = 1'b0;
    case (d_state_q)
      IDLE: if (dwb_stb_i) begin
        d_adr_d   = dwb_adr_i;
        d_wre_d   = dwb_wre_i;
        d_sel_d   = dwb_sel_i;
        d_dat_d   = dwb_dat_i;
        d_state_d = DWS3 == 3'd0 ? ACK : WAIT;
        d_cnt_d   = DWS3;
        d_hit     = DWS3 == 3'd0;
      end
      WAIT: begin
        d_state_d = !dwb_stb_i ? IDLE : d_cnt_q == 3'd1 ? ACK : WAIT;
        d_cnt_d   = !dwb_stb_i ? 3'd0 : d_cnt_q - 3'd1;
        d_hit     = dwb_stb_i && d_cnt_q == 3'd1;
      end
      default: d_state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      i_state_q <= IDLE;
      i_cnt_q   <= '0;
      iwb_ack_o <= 1'b0;
      iwb_dat_o <= '0;
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_adr_q   <= i_adr_d;
      iwb_ack_o <= i_hit;
      if (i_hit) iwb_dat_o <= mem[i_adr_d];
    end
  end
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      d_state_q <= IDLE;
      d_cnt_q   <= '0;
      dwb_ack_o <= 1'b0;
      dwb_dat_o <= '0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_adr_q   <= d_adr_d;
      d_wre_q   <= d_wre_d;
      d_sel_q   <= d_sel_d;
      d_dat_q   <= d_dat_d;
      dwb_ack_o <= d_hit;
      if (d_hit) dwb_dat_o <= mem[d_adr_d];
    end
  end
  // Non-blocking write gives read-before-write on both ports in the same edge.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i && d_hit && d_wre_d)
      for (int k = 0; k < 4; k++)
        if (d_sel_d[k]) mem[d_adr_d][8*k +: 8] <= d_dat_d[8*k +: 8];
  end
endmodule

// File: tb/tb_aemb_wb_ram.sv
// tb_aemb_wb_ram: directed and randomized checks of two RAM configurations against a word-map model
module tb_aemb_wb_ram;
  localparam int AW = 10;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [AW-1:2] a_iadr, a_dadr, b_iadr, b_dadr;
  logic          a_istb, a_dstb, a_wre, b_istb, b_dstb, b_wre;
  logic [3:0]    a_sel, b_sel;
  logic [31:0]   a_wdat, b_wdat, a_idat, a_ddat, b_idat, b_ddat;
  logic          a_iack, a_dack, b_iack, b_dack;
  aemb_wb_ram #(.AW(AW), .IWS(0), .DWS(0)) dut_a (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .iwb_adr_i(a_iadr), .iwb_stb_i(a_istb), .iwb_dat_o(a_idat), .iwb_ack_o(a_iack),
    .dwb_adr_i(a_dadr), .dwb_stb_i(a_dstb), .dwb_wre_i(a_wre), .dwb_sel_i(a_sel),
    .dwb_dat_i(a_wdat), .dwb_dat_o(a_ddat), .dwb_ack_o(a_dack));
  aemb_wb_ram #(.AW(AW), .IWS(3), .DWS(2)) dut_b (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .iwb_adr_i(b_iadr), .iwb_stb_i(b_istb), .iwb_dat_o(b_idat), .iwb_ack_o(b_iack),
    .dwb_adr_i(b_dadr), .dwb_stb_i(b_dstb), .dwb_wre_i(b_wre), .dwb_sel_i(b_sel),
    .dwb_dat_i(b_wdat), .dwb_dat_o(b_ddat), .dwb_ack_o(b_dack));
  int nvec = 0, nerr = 0;
  logic [31:0] m [int];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~mask) | (dat & mask);
  endfunction
  function automatic logic ackof(input int p);
    return p == 0 ? a_iack : p == 1 ? a_dack : p == 2 ? b_iack : b_dack;
  endfunction
  function automatic logic [31:0] datof(input int p);
    return p == 0 ? a_idat : p == 1 ? a_ddat : p == 2 ? b_idat : b_ddat;
  endfunction
  function automatic int key(input int p, input logic [AW-1:2] adr);
    return (p / 2) * 65536 + int'(adr);
  endfunction
  // p: 0 = A instr, 1 = A data, 2 = B instr (3 wait states), 3 = B data (2 wait states)
  task automatic op(input int p, input logic we, input logic [AW-1:2] adr, input logic [3:0] sel,
                    input logic [31:0] dat, input string tag, output logic [31:0] rd);
    int lat, k;
    @(negedge clk);
    chk({tag, "_ackgap"}, 32'(ackof(p)), 0);
    case (p)
      0: begin a_istb = 1; a_iadr = adr; end
      1: begin a_dstb = 1; a_wre = we; a_dadr = adr; a_sel = sel; a_wdat = dat; end
      2: begin b_istb = 1; b_iadr = adr; end
      default: begin b_dstb = 1; b_wre = we; b_dadr = adr; b_sel = sel; b_wdat = dat; end
    endcase
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ackof(p) && lat < 20);
    rd = datof(p);
    a_istb = 0; a_dstb = 0; b_istb = 0; b_dstb = 0;
    chk({tag, "_lat"}, 32'(lat), p < 2 ? 1 : p == 2 ? 4 : 3);
    k = key(p, adr);
    if (m.exists(k)) chk({tag, "_dat"}, rd, m[k]);
    if (we) m[k] = merge(m.exists(k) ? m[k] : 32'h0, dat, sel);
  endtask
  initial begin
    logic [31:0] rd;
    logic [AW-1:2] ia, da;
    a_istb = 0; a_dstb = 0; b_istb = 0; b_dstb = 0; a_wre = 0; b_wre = 0;
    a_iadr = '0; a_dadr = '0; b_iadr = '0; b_dadr = '0;
    a_sel = '0; b_sel = '0; a_wdat = '0; b_wdat = '0;
    @(negedge clk);
    a_istb = 1; a_dstb = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_a_iack", 32'(a_iack), 0);
      chk("rst_a_dack", 32'(a_dack), 0);
      chk("rst_a_idat", a_idat, 0);
      chk("rst_b_ddat", b_ddat, 0);
    end
    a_istb = 0; a_dstb = 0; rst = 0;
    op(1, 1, 8'h10, 4'hF, 32'hDEADBEEF, "wr10", rd);
    op(1, 0, 8'h10, 4'h0, 32'h0, "rd10", rd);
    chk("rd10_const", rd, 32'hDEADBEEF);
    op(0, 0, 8'h10, 4'h0, 32'h0, "ird10", rd);
    op(1, 1, 8'h10, 4'hF, 32'h11223344, "pre10", rd);
    op(1, 1, 8'h10, 4'h2, 32'h0000AA00, "sel2", rd);
    op(1, 0, 8'h10, 4'h0, 32'h0, "rdsel2", rd);
    chk("sel2_const", rd, 32'h1122AA44);
    op(1, 1, 8'h10, 4'h0, 32'hFFFFFFFF, "sel0", rd);
    op(1, 0, 8'h10, 4'h0, 32'h0, "rdsel0", rd);
    chk("sel0_const", rd, 32'h1122AA44);
    op(1, 1, 8'h20, 4'hF, 32'h0, "clr20", rd);
    @(negedge clk);
    a_istb = 1; a_iadr = 8'h20;
    a_dstb = 1; a_wre = 1; a_dadr = 8'h20; a_sel = 4'hF; a_wdat = 32'h12345678;
    @(negedge clk);
    a_istb = 0; a_dstb = 0;
    chk("coll_iack", 32'(a_iack), 1);
    chk("coll_dack", 32'(a_dack), 1);
    chk("coll_idat", a_idat, 0);
    chk("coll_ddat", a_ddat, 0);
    m[key(1, 8'h20)] = 32'h12345678;
    op(1, 0, 8'h20, 4'h0, 32'h0, "rd20", rd);
    chk("rd20_const", rd, 32'h12345678);
    op(0, 0, 8'h20, 4'h0, 32'h0, "ird20", rd);
    for (int i = 0; i < 16; i++) op(1, 1, 8'(i), 4'hF, $urandom, "fill", rd);
    for (int i = 0; i < 60; i++) begin
      int p;
      logic we;
      p = int'($urandom_range(0, 1));
      we = p == 1 && $urandom_range(0, 1) == 1;
      op(p, we, 8'($urandom_range(0, 15)), 4'($urandom), $urandom, p == 0 ? "rnd_i" : "rnd_d", rd);
    end
    @(negedge clk);
    ia = 8'($urandom_range(0, 15)); da = 8'($urandom_range(0, 15));
    a_istb = 1; a_iadr = ia; a_dstb = 1; a_wre = 0; a_dadr = da;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hold_iack", 32'(a_iack), i % 2 == 0 ? 1 : 0);
      chk("hold_dack", 32'(a_dack), i % 2 == 0 ? 1 : 0);
      if (i % 2 == 0) begin
        chk("hold_idat", a_idat, m[key(0, ia)]);
        chk("hold_ddat", a_ddat, m[key(1, da)]);
        ia = 8'($urandom_range(0, 15)); da = 8'($urandom_range(0, 15));
        a_iadr = ia; a_dadr = da;
      end
    end
    a_istb = 0; a_dstb = 0;
    op(3, 1, 8'h05, 4'hF, 32'hCAFEF00D, "b_wr5", rd);
    op(2, 0, 8'h05, 4'h0, 32'h0, "b_ird5", rd);
    chk("b_ird5_const", rd, 32'hCAFEF00D);
    @(negedge clk);
    b_istb = 1; b_iadr = 8'h05;
    @(negedge clk);
    @(negedge clk);
    b_istb = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_iack", 32'(b_iack), 0);
    end
    op(2, 0, 8'h05, 4'h0, 32'h0, "b_after_abort", rd);
    @(negedge clk);
    b_dstb = 1; b_wre = 1; b_dadr = 8'h05; b_sel = 4'hF; b_wdat = 32'h0BADBAD0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rstw_dack", 32'(b_dack), 0);
    chk("rstw_ddat", b_ddat, 0);
    chk("rstw_idat", b_idat, 0);
    chk("rstw_a_idat", a_idat, 0);
    @(negedge clk);
    chk("rstw_dack2", 32'(b_dack), 0);
    rst = 0; b_dstb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_noack", 32'(b_dack), 0);
    end
    op(3, 0, 8'h05, 4'h0, 32'h0, "b_rd5_after_rst", rd);
    chk("b_rd5_const", rd, 32'hCAFEF00D);
    op(1, 0, 8'h20, 4'h0, 32'h0, "a_rd20_after_rst", rd);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
